iter_multiplier: RTL and testbench
==================================

Name: iter_multiplier

Overview:
- Sequential shift-add multiplier; the multiply counterpart of the team's iterative restoring divider.
- Same start/ready handshake and same sign mode, so datapath FSMs can drive both blocks identically.
- Computes a full 2*WIDTH-bit product of two WIDTH-bit operands, one partial product per clock.
- Sits beside the divider in the arithmetic datapath, where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sign  input  1  0 = unsigned operands; 1 = two's-complement operands. Sampled with start.
- start  input  1  single-cycle request; operands are valid in the same cycle.
- multiplicand  input  WIDTH  operand A, sampled when start=1.
- multiplier  input  WIDTH  operand B, sampled when start=1.
- product  output  2*WIDTH  result register; holds its value until the next completion or reset.
- busy  output  1  high while an operation is in progress.
- ready  output  1  one-cycle pulse: product is valid.

Behaviour:
- Reset (clk edge with reset=1): product=0, busy=0, ready=0, FSM=IDLE, counter=0. Reset has priority over start.
- FSM states:
  - IDLE: busy=0, ready=0.
  - RUN: busy=1.
  - DONE: ready=1 and busy=0 for exactly one cycle, then IDLE.
- start=1 in any state (IDLE, RUN, DONE) at edge E0:
  - magA = |A| when sign=1 and A[WIDTH-1]=1, else A; magB likewise. Magnitudes are WIDTH-bit unsigned; the most-negative value maps to 2^(WIDTH-1).
  - neg = sign & (A[WIDTH-1] ^ B[WIDTH-1]).
  - acc (2*WIDTH bits) = 0; ashift = zero-extended magA; counter = WIDTH; go to RUN.
  - A start while in RUN aborts the current operation with no ready pulse and restarts with the new operands.
- Each RUN edge:
  - if magB[0], acc += ashift;
  - ashift <<= 1; magB >>= 1; counter -= 1.
- Termination: the RUN edge where the counter reaches 0. At that edge:
  - product = neg ? (~acc_next + 1) : acc_next, where acc_next includes this edge's partial add;
  - go to DONE.
- Latency: start at E0, product updated at E(WIDTH), ready high during the cycle after E(WIDTH).
- Width rules:
  - Unsigned: product is exact within 2*WIDTH bits.
  - Signed: product is exact as 2*WIDTH-bit two's complement, including (-2^(W-1))^2 = 2^(2W-2).
  - All negation happens at 2*WIDTH bits.
- Operands may change freely after the start cycle; the block never re-samples them.
- Zero result with neg=1 yields 0; the negation of 0 is 0.

Optional Feature:
- Macro: ITER_MULT_EARLY_EXIT_EN.
- Defined: termination also occurs on the first RUN edge where the shifted magB becomes 0.
  - Latency = max(1, index of the highest set bit of magB + 1) iterations.
  - multiplier=0 or 1 finishes at E1.
  - ready still pulses exactly one cycle after the final update edge.
- Not defined: always exactly WIDTH iterations, fixed latency.
- Result values are identical in both builds.

Decomposition:
- Package iter_mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the counter-width function clog2(WIDTH+1).
- One sub-module: twos_mag (parameterised width).
  - Conditional two's-complement magnitude/negate.
  - Instantiated for both operand magnitudes and for the final product negate.

Test Plan (WIDTH=8):
- Unsigned max: sign=0, A=255, B=255 -> product=0xFE01. ready pulses during the 9th cycle after the start edge (8 iterations). busy high for 8 cycles.
- Signed mixed and extreme:
  - A=-3 (0xFD), B=5 -> 0xFFF1.
  - A=-128, B=-128 -> 0x4000.
  - A=-128, B=127 -> 0xC080.
- Restart and zero: start A=10, B=20, then start again 3 cycles later with A=7, B=6. No ready for the first operation; product=42 and ready 8 iterations after the second start. Then A=0, B=77 -> product=0.
- Reset mid-operation: assert reset 4 cycles after start. product=0, busy=0, and ready never asserts. A subsequent start A=2, B=3 -> 6.
- Early exit, macro defined: B=1 -> ready 1 iteration after start; B=0x80 -> 8 iterations. Macro undefined: both take 8. Products are equal in both builds.
- Hold: after completion, change the operands without asserting start. product is unchanged and ready stays 0.

Source files
------------

// File: rtl/iter_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package iter_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; the counter must hold values 0..WIDTH, so callers pass WIDTH+1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iter_multiplier_twos_mag.sv
// Conditional two's-complement negate: result = negate ? -value : value.
// Used for operand magnitudes and for re-applying the sign to the product.
module twos_mag #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // Pure combinational negate; negating 0 wraps back to 0.
  always_comb begin
    result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
  end

endmodule

// File: rtl/iter_multiplier.sv
// Sequential shift-add multiplier, one partial product per clock.
// Handshake: start is a single-cycle request with operands valid in that
// cycle (accepted in any state, aborting a running operation); busy is high
// while iterating; ready pulses for one cycle when product holds the result.
// Build option ITER_MULT_EARLY_EXIT_EN: stop as soon as the remaining
// multiplier magnitude is zero instead of always running WIDTH iterations.
module iter_multiplier
  import iter_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sign,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               ready
);

  localparam int CW = clog2(WIDTH + 1);

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] ashift;
  logic [WIDTH-1:0]   mag_b_r;
  logic [CW-1:0]      cnt;
  logic               neg_r;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mag_b_next;
  logic [CW-1:0]      cnt_next;
  logic               finish;
  logic [2*WIDTH-1:0] prod_next;

  // Operand magnitudes are formed at WIDTH bits; the most-negative value
  // maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  twos_mag #(.W(WIDTH)) u_mag_a (
    .value  (multiplicand),
    .negate (sign & multiplicand[WIDTH-1]),
    .result (mag_a)
  );

  twos_mag #(.W(WIDTH)) u_mag_b (
    .value  (multiplier),
    .negate (sign & multiplier[WIDTH-1]),
    .result (mag_b)
  );

  // Final sign is re-applied at full product width.
  twos_mag #(.W(2*WIDTH)) u_prod_neg (
    .value  (acc_next),
    .negate (neg_r),
    .result (prod_next)
  );

  // Next-iteration datapath values and the termination test.
  always_comb begin
    neg        = sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    acc_next   = mag_b_r[0] ? (acc + ashift) : acc;
    mag_b_next = mag_b_r >> 1;
    cnt_next   = cnt - {{(CW-1){1'b0}}, 1'b1};
`ifdef ITER_MULT_EARLY_EXIT_EN
    finish     = (cnt_next == '0) || (mag_b_next == '0);
`else
    finish     = (cnt_next == '0);
`endif
  end

  // Control FSM and datapath registers; reset wins over start, start wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      ashift  <= '0;
      mag_b_r <= '0;
      cnt     <= '0;
      neg_r   <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else if (start) begin
      state   <= RUN;
      acc     <= '0;
      ashift  <= {{WIDTH{1'b0}}, mag_a};
      mag_b_r <= mag_b;
      cnt     <= CW'(WIDTH);
      neg_r   <= neg;
      busy    <= 1'b1;
      ready   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc     <= acc_next;
          ashift  <= ashift << 1;
          mag_b_r <= mag_b_next;
          cnt     <= cnt_next;
          if (finish) begin
            product <= prod_next;
            state   <= DONE;
            busy    <= 1'b0;
            ready   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier (WIDTH=8): directed cases plus
// randomized operations against an arithmetic reference model.
module tb_iter_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           sign;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           busy;
  logic           ready;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  iter_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sign         (sign),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .ready        (ready)
  );

  // Clock and initial input values.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_product(input logic s, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
    longint va, vb, p;
    va = s ? longint'($signed(a)) : longint'(a);
    vb = s ? longint'($signed(b)) : longint'(b);
    p  = va * vb;
    return p[2*W-1:0];
  endfunction

  // Reference iteration count.
  function automatic int ref_iters(input logic s, input logic [W-1:0] b);
    int mb;
    int n;
    mb = (s && b[W-1]) ? (256 - int'(b)) : int'(b);
`ifdef ITER_MULT_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < W + 1; i++) if ((mb >> i) != 0) n = i + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  // Pulse start for one cycle; returns at the negedge after the start edge.
  task automatic start_pulse(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    sign = s;
    multiplicand = a;
    multiplier = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operands are scrambled to show they are not re-sampled.
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
    sign = 1'($urandom);
  endtask

  // Wait for ready, checking latency, busy duration, product and pulse width.
  task automatic wait_done(input string tag, input int exp_iters);
    int n;
    int busy_n;
    logic [2*W-1:0] exp_p;
    n = 0;
    busy_n = 0;
    while (!ready && n < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      n++;
    end
    exp_p = exp_q.pop_front();
    check({tag, "_latency"}, 32'(n), 32'(exp_iters));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_iters));
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    check({tag, "_busy_at_ready"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    exp_q.push_back(ref_product(s, a, b));
    start_pulse(s, a, b);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    wait_done(tag, ref_iters(s, b));
  endtask

  initial begin
    logic [2*W-1:0] held;
    int ready_seen;
    reset = 1'b1;
    sign = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(negedge clk);
    check("reset_product", 32'(product), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    reset = 1'b0;

    // Directed values from hand arithmetic.
    check("model_umax", 32'(ref_product(1'b0, 8'd255, 8'd255)), 32'h0000_FE01);
    run_op("umax", 1'b0, 8'd255, 8'd255);
    run_op("s_m3x5", 1'b1, 8'hFD, 8'd5);
    run_op("s_m128sq", 1'b1, 8'h80, 8'h80);
    run_op("s_m128x127", 1'b1, 8'h80, 8'h7F);
    check("out_m128x127", 32'(product), 32'h0000_C080);
    run_op("b_one", 1'b0, 8'd200, 8'd1);
    run_op("b_0x80", 1'b0, 8'd3, 8'h80);
    run_op("b_zero", 1'b1, 8'hF0, 8'd0);

    // Restart mid-operation: the first operation must never report.
    start_pulse(1'b0, 8'd10, 8'd20);
    ready_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready) ready_seen++;
    end
    exp_q.push_back(ref_product(1'b0, 8'd7, 8'd6));
    start_pulse(1'b0, 8'd7, 8'd6);
    check("restart_no_ready", 32'(ready_seen), 32'd0);
    wait_done("restart", ref_iters(1'b0, 8'd6));
    check("restart_42", 32'(product), 32'd42);
    run_op("zero_a", 1'b0, 8'd0, 8'd77);

    // Reset mid-operation.
    start_pulse(1'b0, 8'd99, 8'd99);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_product", 32'(product), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    ready_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready) ready_seen++;
    end
    check("midreset_no_ready", 32'(ready_seen), 32'd0);
    run_op("after_reset", 1'b0, 8'd2, 8'd3);

    // Hold: operands move without start.
    held = product;
    ready_seen = 0;
    repeat (6) begin
      @(negedge clk);
      multiplicand = W'($urandom);
      multiplier = W'($urandom);
      sign = 1'($urandom);
      if (ready) ready_seen++;
    end
    check("hold_product", 32'(product), 32'(held));
    check("hold_no_ready", 32'(ready_seen), 32'd0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 1'($urandom), W'($urandom), W'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
